pc_unit: RTL
============

# pc_unit

Parametrised program-counter unit for the pipelined MIPS fetch stage. It holds the fetch PC and selects the next PC from sequential increment, taken-branch redirect, jump, or return. An optional return-address stack (RAS) predicts return targets. It supersedes the single-register PC and has explicit stall and redirect priority.

## Interface
Parameters:
- PC_SIZE, 18, PC width in bits
- STEP, 4, sequential increment added per fetch
- RESET_PC, 0, PC value loaded on reset
- RAS_DEPTH, 4, RAS entries (power of two, ≥2)

Ports:
- clk  input  1  clock; state updates on falling edge
- rst  input  1  asynchronous, active-low reset
- stall  input  1  hold PC (hazard unit)
- branch_taken  input  1  redirect from EX, highest functional priority
- branch_target  input  PC_SIZE  branch destination
- jump  input  1  jump request from ID
- call  input  1  qualifies jump as a call (jal); push return address
- jump_target  input  PC_SIZE  jump destination
- ret  input  1  return request (jr $ra) from ID
- jr_target  input  PC_SIZE  register value of $ra (fallback target)
- pc_out  output  PC_SIZE  current fetch PC (registered)
- pc_seq  output  PC_SIZE  pc_out + STEP (combinational)
- ras_count  output  clog2(RAS_DEPTH+1)  valid RAS entries (registered)
- ras_full  output  1  ras_count == RAS_DEPTH
- ras_empty  output  1  ras_count == 0

## Operation
- Next-PC priority, evaluated each falling edge:
  1. branch_taken → branch_target.
  2. stall → hold pc_out.
  3. jump → jump_target; if call also asserted, push pc_seq.
  4. ret → RAS top if nonempty (pop), else jr_target.
  5. Otherwise → pc_seq.
- Lower-priority requests in the same cycle are dropped, with no RAS side effects. Examples: call during stall or branch_taken does not push; jump+ret takes the jump and does not pop.
- call without jump is ignored.
- RAS is circular with a top pointer:
  - Push when full overwrites the oldest entry; ras_count saturates at RAS_DEPTH.
  - Pop decrements the pointer and count.
  - ret when empty uses jr_target; count stays 0 and the pointer is unchanged.
- Arithmetic is modulo 2^PC_SIZE. pc_seq wraps from 2^PC_SIZE−STEP to 0 with no flag.
- Reset mid-operation clears all state immediately, regardless of pending requests.

## Timing
- rst low (asynchronous): pc_out=RESET_PC, ras_count=0, pointer=0, all RAS entries=0.
  - ras_empty=1, ras_full=0, pc_seq=RESET_PC+STEP.
  - On the first falling edge after rst rises, normal selection applies.
- Latency: a request sampled at falling edge N is visible on pc_out right after edge N (one edge).
- The RAS push and pop commit on the same edge as the PC update.
- pc_seq, ras_full, and ras_empty follow registered state combinationally. There is no input-to-output combinational path except through pc_out.
- Requests are level-sampled per edge; no handshake. The requester deasserts after one edge unless it intends a repeat.

## Configuration
- PC_RAS_EN defined: the RAS is built as described.
- PC_RAS_EN undefined: no RAS storage.
  - ret always selects jr_target; call has no side effect beyond jump.
  - ras_count=0, ras_empty=1, ras_full=0 constantly.
  - Next-PC priority is unchanged.

## Test plan
- Reset/sequential: hold rst=0, then release with STEP=4 → pc_out 0, 4, 8, 12 on successive falling edges. Assert rst=0 mid-count → pc_out=0 immediately, without waiting for an edge.
- Stall vs branch: pc_out=0x20, stall=1 for 2 edges → holds 0x20. Then stall=1 with branch_taken=1, branch_target=0x100 → pc_out=0x100.
- Call/return: at pc_out=0x40, jump+call to 0x200 → pc_out=0x200, ras_count=1. Later ret with jr_target=0x3FFFF → pc_out=0x44, ras_count=0.
- RAS overflow/underflow (RAS_DEPTH=4): perform 5 calls from 0x0, 0x10, 0x20, 0x30, 0x40.
  - After the calls: ras_full=1, count=4.
  - 4 rets → targets 0x44, 0x34, 0x24, 0x14.
  - 5th ret with jr_target=0x80 → pc_out=0x80, count stays 0.
- Priority/drop: jump+call with stall=1 → pc_out held, ras_count unchanged. jump to 0x300 with ret=1 → pc_out=0x300, no pop.
- Wrap and config: pc_out=0x3FFFC, PC_SIZE=18 → next pc_out=0. With PC_RAS_EN undefined, call then ret with jr_target=0x1234 → pc_out=0x1234, ras_count=0.

Source files
------------

// File: rtl/pc_unit_if.sv
// pc_unit_if: request/response bundle between the fetch-stage controllers
// (hazard unit, ID, EX) and the program-counter unit.
// The fetch side (master) drives the redirect requests; the PC unit (slave)
// returns the registered fetch PC, its sequential successor and RAS status.
interface pc_unit_if #(
    parameter int PC_SIZE   = 18,
    parameter int RAS_DEPTH = 4
);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic               stall;
    logic               branch_taken;
    logic [PC_SIZE-1:0] branch_target;
    logic               jump;
    logic               call;
    logic [PC_SIZE-1:0] jump_target;
    logic               ret;
    logic [PC_SIZE-1:0] jr_target;

    logic [PC_SIZE-1:0] pc_out;
    logic [PC_SIZE-1:0] pc_seq;
    logic [CNT_W-1:0]   ras_count;
    logic               ras_full;
    logic               ras_empty;

    modport master (
        output stall, branch_taken, branch_target,
        output jump, call, jump_target, ret, jr_target,
        input  pc_out, pc_seq, ras_count, ras_full, ras_empty
    );

    modport slave (
        input  stall, branch_taken, branch_target,
        input  jump, call, jump_target, ret, jr_target,
        output pc_out, pc_seq, ras_count, ras_full, ras_empty
    );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: fetch program counter with prioritised next-PC selection and an
// optional circular return-address stack.
//
// Build option: define PC_RAS_EN to build the return-address stack. Without
// it, ret always resolves to jr_target and the RAS status outputs are tied
// to "empty".
//
// All state updates on the falling edge of clk; rst is asynchronous and
// active-low.
//
// Next-PC priority: branch_taken > stall > jump (+call push) > ret (pop or
// jr_target) > sequential. A request that loses arbitration has no side
// effect on the stack.
module pc_unit #(
    parameter int                PC_SIZE   = 18,
    parameter int                STEP      = 4,
    parameter logic [PC_SIZE-1:0] RESET_PC = '0,
    parameter int                RAS_DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    pc_unit_if.slave bus
);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam int PTR_W = $clog2(RAS_DEPTH);

    logic [PC_SIZE-1:0] pc_q;
    logic [PC_SIZE-1:0] pc_nxt;
    logic [PC_SIZE-1:0] pc_seq;
    logic               sel_jump;
    logic               sel_ret;
    logic               ras_top_valid;
    logic [PC_SIZE-1:0] ras_top;

    // Sequential successor; wraps silently modulo 2^PC_SIZE.
    assign pc_seq = pc_q + PC_SIZE'(STEP);

    // Which request wins this edge; stack side effects follow these only.
    assign sel_jump = !bus.branch_taken && !bus.stall && bus.jump;
    assign sel_ret  = !bus.branch_taken && !bus.stall && !bus.jump && bus.ret;

    // Next-PC arbitration.
    always_comb begin
        pc_nxt = pc_seq;
        if (bus.branch_taken) begin
            pc_nxt = bus.branch_target;
        end else if (bus.stall) begin
            pc_nxt = pc_q;
        end else if (bus.jump) begin
            pc_nxt = bus.jump_target;
        end else if (bus.ret) begin
            pc_nxt = ras_top_valid ? ras_top : bus.jr_target;
        end
    end

    // Fetch PC register.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_nxt;
        end
    end

`ifdef PC_RAS_EN
    // The pointer addresses the next free slot; the top entry sits one below
    // it. Pushing while full simply overwrites the oldest slot, since the
    // pointer wraps around the power-of-two array.
    logic [PC_SIZE-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]   ras_ptr;
    logic [PTR_W-1:0]   ptr_dec;
    logic [CNT_W-1:0]   ras_cnt;
    logic               do_push;
    logic               do_pop;
    logic               cnt_full;

    assign ptr_dec       = ras_ptr - PTR_W'(1);
    assign ras_top       = ras_mem[ptr_dec];
    assign ras_top_valid = (ras_cnt != '0);
    assign cnt_full      = (ras_cnt == CNT_W'(RAS_DEPTH));
    assign do_push       = sel_jump && bus.call;
    assign do_pop        = sel_ret && ras_top_valid;

    // Return-address stack: push on a winning call, pop on a winning return.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            ras_ptr <= '0;
            ras_cnt <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem[i] <= '0;
            end
        end else if (do_push) begin
            ras_mem[ras_ptr] <= pc_seq;
            ras_ptr          <= ras_ptr + PTR_W'(1);
            if (!cnt_full) begin
                ras_cnt <= ras_cnt + CNT_W'(1);
            end
        end else if (do_pop) begin
            ras_ptr <= ptr_dec;
            ras_cnt <= ras_cnt - CNT_W'(1);
        end
    end

    assign bus.ras_count = ras_cnt;
    assign bus.ras_full  = cnt_full;
    assign bus.ras_empty = !ras_top_valid;
`else
    // No stack: a return always takes the register value of $ra.
    logic sel_unused;

    assign ras_top_valid = 1'b0;
    assign ras_top       = '0;
    assign sel_unused    = sel_jump ^ sel_ret ^ bus.call;

    assign bus.ras_count = '0;
    assign bus.ras_full  = 1'b0;
    assign bus.ras_empty = 1'b1;
`endif

    assign bus.pc_out = pc_q;
    assign bus.pc_seq = pc_seq;

endmodule
